// File: rtl/bcd_pkg.sv
// Shared widths, limits and types for the BCD-to-decimal decoder.
package bcd_pkg;
    localparam int BCD_W = 4;
    localparam int DEC_W = 10;

    typedef logic [BCD_W-1:0] bcd_t;
    typedef logic [DEC_W-1:0] dec_t;

    localparam bcd_t BCD_MAX        = 4'd9;
    localparam dec_t PRESET_PATTERN = {DEC_W{1'b1}};
endpackage

// File: rtl/bcd_onehot_dec.sv
// Purely combinational BCD digit to one-hot decimal decode with a legality flag.
module bcd_onehot_dec
    import bcd_pkg::*;
(
    input  bcd_t bcd,
    output dec_t onehot,
    output logic valid
);

    // Codes 10..15 match no line, so the one-hot vector is naturally all-zero for them.
    generate
        for (genvar gi = 0; gi < DEC_W; gi++) begin : g_line
            assign onehot[gi] = (bcd == bcd_t'(gi));
        end
    endgenerate

    assign valid = (bcd <= BCD_MAX);

endmodule

// File: rtl/bcd_to_dec.sv
// Registered BCD-to-decimal decoder with synchronous reset, lamp-test preset and
// optional active-low outputs.
module bcd_to_dec
    import bcd_pkg::*;
#(
    parameter bit OUT_ACTIVE_LOW = 1'b0
)(
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             Preset,
    input  logic [BCD_W-1:0] in,
    output logic [DEC_W-1:0] out,
    output logic             invalid
);

    // Inversion is folded in ahead of the flops so out stays a pure register.
    localparam dec_t POLARITY_MASK = OUT_ACTIVE_LOW ? PRESET_PATTERN : '0;

    dec_t onehot;
    logic valid;
    dec_t dec_next;
    logic invalid_next;
    dec_t out_reg;
    logic invalid_reg;

    bcd_onehot_dec u_dec (
        .bcd    (in),
        .onehot (onehot),
        .valid  (valid)
    );

    always_comb begin
        dec_next     = '0;
        invalid_next = 1'b0;
        if (Preset) begin
            dec_next = PRESET_PATTERN;
        end else if (valid) begin
            dec_next = onehot;
        end else begin
            invalid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            out_reg     <= POLARITY_MASK;
            invalid_reg <= 1'b0;
        end else begin
            out_reg     <= dec_next ^ POLARITY_MASK;
            invalid_reg <= invalid_next;
        end
    end

    assign out     = out_reg;
    assign invalid = invalid_reg;

endmodule

// File: tb/tb_bcd_to_dec.sv
// Scoreboard bench for bcd_to_dec: both output polarities are driven from the same
// stimulus and checked by a monitor that pops expected results one cycle later.
module tb_bcd_to_dec;

    logic       clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Preset = 1'b0;
    logic [3:0] in = 4'd0;
    logic [9:0] out_hi;
    logic       invalid_hi;
    logic [9:0] out_lo;
    logic       invalid_lo;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [9:0] out;
        logic       inv;
        string      name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    bcd_to_dec #(.OUT_ACTIVE_LOW(1'b0)) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .Preset  (Preset),
        .in      (in),
        .out     (out_hi),
        .invalid (invalid_hi)
    );

    bcd_to_dec #(.OUT_ACTIVE_LOW(1'b1)) dut_low (
        .clk     (clk),
        .Reset_n (Reset_n),
        .Preset  (Preset),
        .in      (in),
        .out     (out_lo),
        .invalid (invalid_lo)
    );

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %03h, expected %03h", name, act, exp);
    endtask

    // Drive one edge worth of inputs and queue what the active-high decoder must show.
    task automatic step(input logic r, input logic p, input logic [3:0] d,
                        input logic [9:0] e_out, input logic e_inv, input string name);
        exp_t e;
        @(negedge clk);
        Reset_n = r;
        Preset  = p;
        in      = d;
        e.out  = e_out;
        e.inv  = e_inv;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, so one expected entry is consumed per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, "_out"},         out_hi,            e.out);
                check({e.name, "_inv"},         {9'd0, invalid_hi}, {9'd0, e.inv});
                check({e.name, "_out_low"},     out_lo,            ~e.out);
                check({e.name, "_inv_low"},     {9'd0, invalid_lo}, {9'd0, e.inv});
                $display("txn %-14s rst_n=%0b pre=%0b in=%0d out=%03h inv=%0b out_low=%03h inv_low=%0b",
                         e.name, Reset_n, Preset, in, out_hi, invalid_hi, out_lo, invalid_lo);
            end
        end
    end

    logic [9:0] sweep_exp [10] = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010,
                                   10'h020, 10'h040, 10'h080, 10'h100, 10'h200};

    initial begin
        step(1'b0, 1'b0, 4'd0, 10'h000, 1'b0, "reset0");
        step(1'b0, 1'b0, 4'd0, 10'h000, 1'b0, "reset1");

        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, 4'(i), sweep_exp[i], 1'b0, $sformatf("dig%0d", i));

        for (int i = 10; i < 16; i++)
            step(1'b1, 1'b0, 4'(i), 10'h000, 1'b1, $sformatf("bad%0d", i));
        step(1'b1, 1'b0, 4'd3, 10'h008, 1'b0, "recover3");

        step(1'b1, 1'b1, 4'd15, 10'h3FF, 1'b0, "preset_in15");
        step(1'b0, 1'b1, 4'd4,  10'h000, 1'b0, "rst_over_pre");
        step(1'b1, 1'b1, 4'd4,  10'h3FF, 1'b0, "pre_after_rst");

        step(1'b1, 1'b0, 4'd9,  10'h200, 1'b0, "edge9");
        step(1'b1, 1'b0, 4'd10, 10'h000, 1'b1, "edge10");
        step(1'b1, 1'b0, 4'd10, 10'h000, 1'b1, "hold10");

        step(1'b1, 1'b0, 4'd7,  10'h080, 1'b0, "run7");
        step(1'b0, 1'b0, 4'd5,  10'h000, 1'b0, "midrst");
        step(1'b1, 1'b0, 4'd5,  10'h020, 1'b0, "after_rst5");
        step(1'b1, 1'b0, 4'd5,  10'h020, 1'b0, "hold5");

        // Bounded drain: the monitor must have consumed every queued expectation.
        repeat (4) @(negedge clk);
        check("drain_queue", 10'(sb.size()), 10'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
